// File: rtl/moore_1011_detector.sv
// moore_1011_detector: overlapping Moore detector that flags the serial pattern 1011 one cycle after its last bit
module moore_1011_detector (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic out
);
  typedef enum logic [2:0] {S0, S1, S2, S3, S4} state_t;
  state_t state_q, state_d;
  logic out_q, out_d;
  always_comb begin
    state_d = S0;
    case (state_q)
      S0: state_d = in ? S1 : S0;
      S1: state_d = in ? S1 : S2;
      S2: state_d = in ? S3 : S0;
      S3: state_d = in ? S4 : S2;
      S4: state_d = in ? S1 : S2;
      default: state_d = S0;
    endcase
    out_d = state_d == S4;
  end
  // out_q mirrors state_q == S4, registered so nothing combinational reaches out from in
  always_ff @(posedge clk) begin
    state_q <= rst ? S0 : state_d;
    out_q <= rst ? 1'b0 : out_d;
  end
  assign out = out_q;
endmodule

// File: tb/tb_moore_1011_detector.sv
// tb_moore_1011_detector: directed and random stimulus checked against a 4-bit shift-register model
module tb_moore_1011_detector;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in = 1'b0;
  logic out;
  logic [3:0] model_q = 4'b0000;
  logic exp_q[$];
  int checks = 0;
  int errors = 0;
  int hits = 0;
  moore_1011_detector dut (.clk(clk), .rst(rst), .in(in), .out(out));
  always #5 clk = ~clk;
  task automatic compare(input string tag);
    logic e;
    if (exp_q.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s scoreboard empty, out=%0b", tag, out);
    end else begin
      e = exp_q.pop_front();
      checks++;
      assert (out === e) else begin
        errors++;
        $error("FAIL %s out=%0b expected=%0b", tag, out, e);
      end
      if (out === 1'b1) hits++;
    end
  endtask
  task automatic do_reset(input logic b);
    @(negedge clk);
    rst = 1'b1;
    in = b;
    @(posedge clk);
    model_q = 4'b0000;
    exp_q.push_back(1'b0);
    #1 compare("reset");
    rst = 1'b0;
  endtask
  task automatic step(input logic b, input string tag);
    @(negedge clk);
    in = b;
    @(posedge clk);
    model_q = {model_q[2:0], b};
    exp_q.push_back(model_q == 4'b1011);
    #1 compare(tag);
  endtask
  task automatic run_bits(input logic [31:0] bits, input int n, input string tag);
    logic [31:0] v;
    v = bits;
    for (int i = n - 1; i >= 0; i--) step(v[i], tag);
  endtask
  initial begin
    logic stop;
    int e0;
    do_reset(1'b1);
    run_bits(32'b1011, 4, "basic");
    do_reset(1'b0);
    hits = 0;
    run_bits(32'b110010111011011, 15, "stream");
    checks++;
    assert (hits == 3) else begin
      errors++;
      $error("FAIL stream_count detections=%0d expected=3", hits);
    end
    do_reset(1'b0);
    run_bits(32'b101011, 6, "s3_to_s2");
    do_reset(1'b0);
    run_bits(32'b101, 3, "pre_reset");
    do_reset(1'b1);
    run_bits(32'b1011, 4, "post_reset");
    do_reset(1'b0);
    run_bits(32'b1011011, 7, "overlap3");
    run_bits(32'b10111011, 8, "overlap4");
    do_reset(1'b0);
    stop = 1'b0;
    e0 = errors;
    for (int i = 0; i < 64 && !stop; i++) begin
      step(1'($urandom_range(0, 1)), "random");
      stop = errors != e0;
    end
    do_reset(1'b0);
    run_bits(32'h0, 20, "zeros");
    do_reset(1'b0);
    run_bits(32'hfffff, 20, "ones");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
